// File: rtl/rx_cmd_streamer_if.sv
// Byte-stream and FIFO-write bundle between the MAC wrapper, rx_cmd_streamer and video_out.
// The slave view belongs to the streamer; the master view is everything around it.
interface rx_cmd_streamer_if #(
   parameter int FIFO_DW = 4,
   parameter int FIFO_UW = 11
) ();
   logic [7:0]         rx_data;
   logic               rx_valid;
   logic               rx_ready;
   logic               rx_last;
   logic               rx_user;
   logic [7:0]         tx_data;
   logic               tx_valid;
   logic               tx_ready;
   logic               tx_last;
   logic [FIFO_DW-1:0] fifow_data;
   logic               fifow_req;
   logic [FIFO_UW-1:0] fifow_used;

   modport slave (
      input  rx_data, rx_valid, rx_last, rx_user, tx_ready, fifow_used,
      output rx_ready, tx_data, tx_valid, tx_last, fifow_data, fifow_req
   );

   modport master (
      output rx_data, rx_valid, rx_last, rx_user, tx_ready, fifow_used,
      input  rx_ready, tx_data, tx_valid, tx_last, fifow_data, fifow_req
   );
endinterface

// File: rtl/rx_cmd_streamer.sv
// Ethernet RX command parser: decodes one header byte per frame, streams payload into the
// video_out FIFO, updates the system mode register and answers STATUS with a 3-byte frame.
module rx_cmd_streamer #(
   parameter int FIFO_DW    = 4,
   parameter int FIFO_UW    = 11,
   parameter int FIFO_AFULL = 2032
) (
   input  logic             clk,
   input  logic             rst,
   rx_cmd_streamer_if.slave bus,
   output logic [3:0]       mode,
   output logic [15:0]      pkt_count,
   output logic [15:0]      drop_count
);
   localparam int R = 8 / FIFO_DW;

   localparam logic [2:0] S_HDR   = 3'd0;
   localparam logic [2:0] S_PAY   = 3'd1;
   localparam logic [2:0] S_SPLIT = 3'd2;
   localparam logic [2:0] S_RESP  = 3'd3;
   localparam logic [2:0] S_DROP  = 3'd4;

   logic [2:0] state;
   logic       en_q;
   logic [3:0] beat_cnt;
   logic [1:0] resp_idx;
   logic       last_q;
   logic [7:0] byte_q;
   logic [7:0] snap_pkt;
   logic [7:0] snap_drop;
   logic       room;
   logic       rx_acc;
   logic       tx_acc;
   logic [3:0] cmd;
   logic [3:0] arg;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign cmd  = bus.rx_data[7:4];
   assign arg  = bus.rx_data[3:0];
   assign room = (bus.fifow_used < FIFO_UW'(FIFO_AFULL));

   // en_q keeps rx_ready low while reset is asserted even though state already reads S_HDR
   always_comb begin
      bus.rx_ready = 1'b0;
      case (state)
         S_HDR, S_DROP: bus.rx_ready = en_q;
         S_PAY:         bus.rx_ready = en_q & room;
         default:       bus.rx_ready = 1'b0;
      endcase
   end

   assign rx_acc = bus.rx_valid & bus.rx_ready;
   assign tx_acc = bus.tx_valid & bus.tx_ready;

   assign bus.fifow_req  = (state == S_SPLIT);
   assign bus.fifow_data = bus.fifow_req ? byte_q[7 -: FIFO_DW] : '0;
   assign bus.tx_valid   = (state == S_RESP);
   assign bus.tx_last    = bus.tx_valid & (resp_idx == 2'd2);

   always_comb begin
      bus.tx_data = 8'h00;
      if (bus.tx_valid) begin
         case (resp_idx)
            2'd0:    bus.tx_data = {4'h3, mode};
            2'd1:    bus.tx_data = snap_pkt;
            default: bus.tx_data = snap_drop;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_HDR;
         en_q       <= 1'b0;
         beat_cnt   <= '0;
         resp_idx   <= '0;
         last_q     <= 1'b0;
         mode       <= '0;
         pkt_count  <= '0;
         drop_count <= '0;
      end else begin
         en_q <= 1'b1;
         case (state)
            S_HDR: begin
               if (rx_acc) begin
                  if (bus.rx_user) begin
                     drop_count <= sat_inc(drop_count);
                     state      <= bus.rx_last ? S_HDR : S_DROP;
                  end else begin
                     state <= bus.rx_last ? S_HDR : S_DROP;
                     case (cmd)
                        4'h0: pkt_count <= sat_inc(pkt_count);
                        4'h1: begin
                           pkt_count <= sat_inc(pkt_count);
                           if (!bus.rx_last) state <= S_PAY;
                        end
                        4'h2: begin
                           mode      <= arg;
                           pkt_count <= sat_inc(pkt_count);
                        end
                        4'h3: begin
                           pkt_count <= sat_inc(pkt_count);
                           last_q    <= bus.rx_last;
                           resp_idx  <= 2'd0;
                           state     <= S_RESP;
                        end
                        default: drop_count <= sat_inc(drop_count);
                     endcase
                  end
               end
            end
            S_PAY: begin
               if (rx_acc) begin
                  if (bus.rx_user) begin
                     drop_count <= sat_inc(drop_count);
                     state      <= bus.rx_last ? S_HDR : S_DROP;
                  end else begin
                     last_q   <= bus.rx_last;
                     beat_cnt <= 4'(R);
                     state    <= S_SPLIT;
                  end
               end
            end
            S_SPLIT: begin
               beat_cnt <= beat_cnt - 4'd1;
               if (beat_cnt == 4'd1) state <= last_q ? S_HDR : S_PAY;
            end
            S_RESP: begin
               if (tx_acc) begin
                  if (resp_idx == 2'd2) state <= last_q ? S_HDR : S_DROP;
                  else                  resp_idx <= resp_idx + 2'd1;
               end
            end
            S_DROP: begin
               if (rx_acc && bus.rx_last) state <= S_HDR;
            end
            default: state <= S_HDR;
         endcase
      end
   end

   // Datapath registers carry no reset: every output they feed is gated by state
   always_ff @(posedge clk) begin
      if (state == S_PAY && rx_acc)  byte_q <= bus.rx_data;
      else if (state == S_SPLIT)     byte_q <= byte_q << FIFO_DW;
      if (state == S_HDR && rx_acc) begin
         snap_pkt  <= pkt_count[7:0];
         snap_drop <= drop_count[7:0];
      end
   end
endmodule

// File: doc/rx_cmd_streamer.md
Name: rx_cmd_streamer

Overview:
- Parametrised successor to the system state manager's Ethernet packet parser.
- Accepts the 125 MHz Ethernet RX byte stream with valid/ready/last/user, decodes a command header per frame, and executes it:
  - streams payload into the video_out write FIFO with backpressure,
  - updates the system mode register,
  - returns a status frame on the TX stream.
- Sits between the Ethernet MAC wrapper and video_out.

Parameters:
- FIFO_DW, 4: video_out FIFO write width in bits. Legal values 1, 2, 4, 8; R = 8/FIFO_DW words per byte.
- FIFO_UW, 11: width of the FIFO used-words input.
- FIFO_AFULL, 2032: payload bytes are refused while fifow_used >= FIFO_AFULL. Must be <= 2^FIFO_UW - R.

Ports:
- clk  in  1  system/Ethernet clock, 125 MHz; also clocks the FIFO write side.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  RX byte.
- rx_valid  in  1  RX byte valid.
- rx_ready  out  1  block can accept an RX byte.
- rx_last  in  1  final byte of frame.
- rx_user  in  1  frame error flag, qualified with rx_valid.
- tx_data  out  8  response byte.
- tx_valid  out  1  response byte valid.
- tx_ready  in  1  MAC accepts response byte.
- tx_last  out  1  final response byte.
- fifow_data  out  FIFO_DW  FIFO write data.
- fifow_req  out  1  FIFO write request, one word per cycle.
- fifow_used  in  FIFO_UW  FIFO used words.
- mode  out  4  current system mode.
- pkt_count  out  16  accepted command frames, saturating.
- drop_count  out  16  dropped/aborted frames, saturating.

Behaviour:
- RX beat accepted when rx_valid & rx_ready at the clk edge. TX beat transfers when tx_valid & tx_ready.
- Reset (rst low, async):
  - state = S_HDR.
  - All outputs 0: rx_ready, tx_*, fifow_*, mode, pkt_count, drop_count.
  - Reset mid-frame abandons the frame. FIFO words already written are not retracted.
  - Remaining bytes of an interrupted frame arrive as a new frame; this is by design.
- States:
  - S_HDR: rx_ready=1. The accepted byte is the header: cmd=[7:4], arg=[3:0].
    - rx_user=1: drop_count++. Next state S_HDR if rx_last, else S_DROP. This takes priority over all decoding.
    - cmd 0x0 NOP: pkt_count++.
    - cmd 0x1 STREAM: pkt_count++. Next state S_PAY, or S_HDR if rx_last (zero-length stream).
    - cmd 0x2 MODE: mode <= arg on the next edge; pkt_count++.
    - cmd 0x3 STATUS: pkt_count++. Next state S_RESP. Response reports counter values before this increment.
    - other cmd: drop_count++.
    - Non-STREAM, non-STATUS commands with rx_last=0: remaining bytes are discarded via S_DROP.
  - S_PAY: rx_ready = (fifow_used < FIFO_AFULL), combinational.
    - Accepted byte with rx_user=1: drop_count++. Next state S_HDR if rx_last, else S_DROP. Nothing written.
    - Otherwise the byte is latched and a beat counter loaded with R. Next state S_SPLIT.
  - S_SPLIT: rx_ready=0. fifow_req=1 every cycle for R cycles.
    - fifow_data carries the MS FIFO_DW bits of the latched byte first.
    - fifow_used is ignored here; FIFO_AFULL margin guarantees space.
    - After the R-th word: S_HDR if the latched byte had rx_last, else S_PAY.
  - Throughput is 1 byte per R+1 cycles. First FIFO write occurs 1 cycle after byte acceptance.
  - S_RESP: rx_ready=0; tx_valid=1. Three bytes:
    - {4'h3, mode}
    - pkt_count[7:0]
    - drop_count[7:0], with tx_last=1
    - tx_data, tx_valid and tx_last hold stable until tx_ready.
    - After the final transfer: S_HDR if the header had rx_last, else S_DROP.
  - S_DROP: rx_ready=1. Discards bytes until an accepted rx_last, then S_HDR. rx_user is ignored here; the frame is already counted.
- Counters saturate at 16'hFFFF, with no wrap.
- fifow_req is never asserted outside S_SPLIT. tx_valid is never asserted outside S_RESP.

Test Plan:
- Reset released; frame {0x1F? no: 0x10, 0xA5, 0x3C (last)}, FIFO_DW=4, fifow_used=0:
  - FIFO receives A,5,3,C in order, 4 fifow_req pulses total.
  - pkt_count=1, return to S_HDR.
- fifow_used held at FIFO_AFULL during a STREAM payload: rx_ready=0 and no writes. Drop fifow_used to 100: the byte is accepted and written.
- Frame {0x27 (last)} then {0x30 (last)}:
  - mode=7.
  - TX bytes 0x37, 0x01, 0x00 with tx_last on the third.
  - Hold tx_ready=0 for 5 cycles mid-response: data stable, no loss.
- STREAM frame with rx_user=1 on the 2nd payload byte (not last), followed by 3 more bytes:
  - Only the 1st byte is written.
  - drop_count=1; remaining bytes discarded; the next header is decoded normally.
- Header 0x9F (unknown) with rx_last: drop_count=1, pkt_count unchanged, no FIFO/TX activity.
- rst pulsed low mid-S_SPLIT and mid-S_RESP:
  - All outputs 0 immediately (async), independent of clk.
  - The next frame after release is decoded as a header.
